// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU definitions: datapath width, condition-flag
//               bundle and the ALU opcode encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Architectural register width
    localparam int XLEN = 32;

    // Condition flags consumed by branch/compare logic
    typedef struct packed {
        logic z;    // result is zero
        logic n;    // result is negative (MSB set)
        logic c;    // carry out; 1 means no borrow on subtract
        logic v;    // signed overflow
    } alu_flags_t;

    // ALU function select seen by the output mux
    typedef enum logic [3:0] {
        ALU_OP_ADD = 4'd0,
        ALU_OP_SUB = 4'd1,
        ALU_OP_AND = 4'd2,
        ALU_OP_OR  = 4'd3,
        ALU_OP_XOR = 4'd4
    } alu_op_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_sub_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_sub_if
// Description : Operand/result bundle for the subtractor slice. The flag
//               signals exist only when ALU_SUB_FLAGS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_sub_if #(
    parameter int WIDTH = alu_pkg::XLEN
);
    logic [WIDTH-1:0] rs1;
    logic [WIDTH-1:0] rs2;
    logic             en;
    logic [WIDTH-1:0] rd;
    logic [WIDTH-1:0] rd_q;
    logic             valid_q;
`ifdef ALU_SUB_FLAGS_EN
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;
`endif

    // Operand source (pipeline / testbench side)
    modport master (
        output rs1, rs2, en,
`ifdef ALU_SUB_FLAGS_EN
        input  flag_z, flag_n, flag_c, flag_v,
`endif
        input  rd, rd_q, valid_q
    );

    // Subtractor side
    modport slave (
        input  rs1, rs2, en,
`ifdef ALU_SUB_FLAGS_EN
        output flag_z, flag_n, flag_c, flag_v,
`endif
        output rd, rd_q, valid_q
    );

endinterface : alu_sub_if
`default_nettype wire

// File: rtl/alu_cla_adder.sv
`default_nettype none
// ============================================================================
// Module      : alu_cla_adder
// Description : Two-level carry-lookahead adder. 4-bit generate/propagate
//               groups feed a flat second-level lookahead so no carry
//               ripples between groups. WIDTH must be a multiple of 4.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cla_adder #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    input  wire logic             cin,
    output logic      [WIDTH-1:0] sum,
    output logic                  cout
);

    localparam int NGRP = WIDTH / 4;

    logic [WIDTH-1:0] w_p;        // bit propagate
    logic [WIDTH-1:0] w_g;        // bit generate
    logic [WIDTH-1:0] w_c;        // carry into each bit
    logic [NGRP-1:0]  w_grp_p;    // group propagate
    logic [NGRP-1:0]  w_grp_g;    // group generate
    logic [NGRP:0]    w_gc;       // carry into each group, [NGRP] is carry-out

    assign w_p = a ^ b;
    assign w_g = a & b;

    // First level: per-group G/P and local lookahead from the group carry-in
    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        localparam int B = 4 * k;

        assign w_grp_p[k] = w_p[B+3] & w_p[B+2] & w_p[B+1] & w_p[B];
        assign w_grp_g[k] = w_g[B+3]
                          | (w_p[B+3] & w_g[B+2])
                          | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                          | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);

        assign w_c[B]   = w_gc[k];
        assign w_c[B+1] = w_g[B] | (w_p[B] & w_gc[k]);
        assign w_c[B+2] = w_g[B+1]
                        | (w_p[B+1] & w_g[B])
                        | (w_p[B+1] & w_p[B] & w_gc[k]);
        assign w_c[B+3] = w_g[B+2]
                        | (w_p[B+2] & w_g[B+1])
                        | (w_p[B+2] & w_p[B+1] & w_g[B])
                        | (w_p[B+2] & w_p[B+1] & w_p[B] & w_gc[k]);
    end

    // Second level: each group carry as a flat sum of products of group G/P
    always_comb begin
        logic v_c;
        logic v_term;
        w_gc = '0;
        for (int k = 0; k <= NGRP; k++) begin
            v_c = cin;
            for (int i = 0; i < k; i++) begin
                v_c = v_c & w_grp_p[i];
            end
            for (int j = 0; j < k; j++) begin
                v_term = w_grp_g[j];
                for (int i = j + 1; i < k; i++) begin
                    v_term = v_term & w_grp_p[i];
                end
                v_c = v_c | v_term;
            end
            w_gc[k] = v_c;
        end
    end

    assign sum  = w_p ^ w_c;
    assign cout = w_gc[NGRP];

endmodule : alu_cla_adder
`default_nettype wire

// File: rtl/alu_sub.sv
`default_nettype none
// ============================================================================
// Module      : alu_sub
// Description : Subtractor slice of the execution-stage ALU. rd = rs1 - rs2
//               combinationally (rs1 + ~rs2 + 1 through a CLA), plus a
//               registered copy with a valid strobe. Defining
//               ALU_SUB_FLAGS_EN adds registered Z/N/C/V flags.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sub
    import alu_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  wire logic clk,
    input  wire logic rst,
    alu_sub_if.slave  bus
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] w_rs2_n;
    logic [WIDTH-1:0] w_diff;
    logic             w_cout;

    logic [WIDTH-1:0] res_q, res_d;
    logic             vld_q, vld_d;

    assign w_rs2_n = ~bus.rs2;

    alu_cla_adder #(
        .WIDTH (WIDTH)
    ) u_cla (
        .a    (bus.rs1),
        .b    (w_rs2_n),
        .cin  (1'b1),
        .sum  (w_diff),
        .cout (w_cout)
    );

    assign bus.rd = w_diff;

    // Next state: capture on en, otherwise hold result and drop valid
    always_comb begin
        res_d = res_q;
        vld_d = 1'b0;
        if (bus.en) begin
            res_d = w_diff;
            vld_d = 1'b1;
        end
    end

    // Result and valid registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
            vld_q <= 1'b0;
        end else begin
            res_q <= res_d;
            vld_q <= vld_d;
        end
    end

    assign bus.rd_q    = res_q;
    assign bus.valid_q = vld_q;

`ifdef ALU_SUB_FLAGS_EN
    alu_flags_t flags_q, flags_d;

    // Flag next state; C is the raw carry-out, so 1 means no borrow
    always_comb begin
        flags_d = flags_q;
        if (bus.en) begin
            flags_d.z = (w_diff == '0);
            flags_d.n = w_diff[MSB];
            flags_d.c = w_cout;
            flags_d.v = (bus.rs1[MSB] != bus.rs2[MSB]) &
                        (w_diff[MSB] != bus.rs1[MSB]);
        end
    end

    // Flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign bus.flag_z = flags_q.z;
    assign bus.flag_n = flags_q.n;
    assign bus.flag_c = flags_q.c;
    assign bus.flag_v = flags_q.v;
`else
    // Carry-out has no consumer without the flag registers
    logic w_unused_cout;
    assign w_unused_cout = w_cout;
`endif

endmodule : alu_sub
`default_nettype wire

// File: tb/tb_alu_sub.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sub
// Description : Directed self-checking bench for alu_sub. Flag checks are
//               active when ALU_SUB_FLAGS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sub;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic [3:0]  f;     // {z, n, c, v}
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs [10];

    alu_sub_if #(.WIDTH(32)) bus ();

    alu_sub #(.WIDTH(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic [3:0] exp);
`ifdef ALU_SUB_FLAGS_EN
        check(tag, {28'd0, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, {28'd0, exp});
`else
        if (exp === 4'hx) check(tag, 32'd0, 32'd1);
`endif
    endtask

    initial begin
        //           rs1           rs2           rd            zncv
        vecs[0] = '{32'h00000001, 32'h00000001, 32'h00000000, 4'b1010};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b1010};
        vecs[2] = '{32'h0000000A, 32'hFFFFFFF6, 32'h00000014, 4'b0000};
        vecs[3] = '{32'hFFFFFFF6, 32'h0000000A, 32'hFFFFFFEC, 4'b0110};
        vecs[4] = '{32'h00000015, 32'h0000000A, 32'h0000000B, 4'b0010};
        vecs[5] = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0100};
        vecs[6] = '{32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011};
        vecs[7] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 4'b0101};
        vecs[8] = '{32'h12345678, 32'h0F0F0F0F, 32'h03254769, 4'b0010};
        vecs[9] = '{32'h00010000, 32'h00000001, 32'h0000FFFF, 4'b0010};

        rst     = 1'b1;
        bus.rs1 = '0;
        bus.rs2 = '0;
        bus.en  = 1'b0;

        // Reset state before any clock edge
        #2;
        check("reset_rd_q", bus.rd_q, 32'd0);
        check("reset_valid", {31'd0, bus.valid_q}, 32'd0);
        check_flags("reset_flags", 4'b0000);

        // rst and en high together at an edge: reset wins
        bus.rs1 = 32'd5;
        bus.rs2 = 32'd3;
        bus.en  = 1'b1;
        @(posedge clk);
        #1;
        check("rst_wins_rd_q", bus.rd_q, 32'd0);
        check("rst_wins_valid", {31'd0, bus.valid_q}, 32'd0);
        check("rd_during_rst", bus.rd, 32'd2);

        @(negedge clk);
        rst = 1'b0;

        // Directed vectors: combinational rd, then captured rd_q/valid/flags
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.rs1 = vecs[i].a;
            bus.rs2 = vecs[i].b;
            bus.en  = 1'b1;
            #1;
            check($sformatf("v%0d_rd", i), bus.rd, vecs[i].d);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_rd_q", i), bus.rd_q, vecs[i].d);
            check($sformatf("v%0d_valid", i), {31'd0, bus.valid_q}, 32'd1);
            check_flags($sformatf("v%0d_flags", i), vecs[i].f);
        end

        // en=0: rd_q and flags hold, valid drops
        @(negedge clk);
        bus.rs1 = 32'd100;
        bus.rs2 = 32'd1;
        bus.en  = 1'b0;
        #1;
        check("hold_rd", bus.rd, 32'd99);
        @(posedge clk);
        #1;
        check("hold_rd_q", bus.rd_q, 32'h0000FFFF);
        check("hold_valid", {31'd0, bus.valid_q}, 32'd0);
        check_flags("hold_flags", 4'b0010);

        // rd follows operands with no clock edge
        #2;
        bus.rs1 = 32'd50;
        bus.rs2 = 32'd8;
        #1;
        check("comb_rd", bus.rd, 32'd42);
        check("comb_rd_q", bus.rd_q, 32'h0000FFFF);

        // Asynchronous reset pulse between edges
        @(negedge clk);
        bus.rs1 = 32'd7;
        bus.rs2 = 32'd2;
        bus.en  = 1'b1;
        @(posedge clk);
        #1;
        check("pre_rst_rd_q", bus.rd_q, 32'd5);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_rd_q", bus.rd_q, 32'd0);
        check("async_rst_valid", {31'd0, bus.valid_q}, 32'd0);
        check_flags("async_rst_flags", 4'b0000);
        check("async_rst_rd", bus.rd, 32'd5);

        // First capture after reset release
        @(negedge clk);
        rst     = 1'b0;
        bus.rs1 = 32'd9;
        bus.rs2 = 32'd4;
        bus.en  = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_rd_q", bus.rd_q, 32'd5);
        check("post_rst_valid", {31'd0, bus.valid_q}, 32'd1);
        check_flags("post_rst_flags", 4'b0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_alu_sub
`default_nettype wire
